// File: rtl/serial_mmio_bridge_pkg.sv
// Shared width codes, FSM state type and width-decoding helpers for the
// TinyQV serial MMIO bridge.
package serial_mmio_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_IDLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    function automatic logic [3:0] nibble_len(input logic [1:0] width);
        case (width)
            W_BYTE:  return 4'd2;
            W_HALF:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_of(input logic [1:0] width);
        case (width)
            W_BYTE:  return 4'b0001;
            W_HALF:  return 4'b0011;
            W_WORD:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/serial_mmio_bridge_if.sv
// CPU-side 4-bit serial MMIO bus; the bridge attaches through the slave modport.
interface serial_mmio_bridge_if #(
    parameter int ADDR_W = 6
);

    logic [ADDR_W-1:0] bus_addr;
    logic [1:0]        bus_read_n;
    logic [1:0]        bus_write_n;
    logic [3:0]        bus_nibble_in;
    logic [3:0]        bus_nibble_out;

    modport master (
        output bus_addr,
        output bus_read_n,
        output bus_write_n,
        output bus_nibble_in,
        input  bus_nibble_out
    );

    modport slave (
        input  bus_addr,
        input  bus_read_n,
        input  bus_write_n,
        input  bus_nibble_in,
        output bus_nibble_out
    );

endinterface

// File: rtl/serial_mmio_bridge.sv
// Serial-to-parallel MMIO bridge: 2/4/8-nibble TinyQV transfers to 32-bit register accesses.
// Optional macro SERIAL_MMIO_SNAPSHOT_EN freezes reg_rdata at read start for coherent nibbles.
module serial_mmio_bridge
    import serial_mmio_pkg::*;
#(
    parameter int         ADDR_W       = 6,
    parameter logic [3:0] RESET_NIBBLE = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_mmio_bridge_if.slave  bus,
    output logic [ADDR_W-1:0]    reg_addr,
    input  logic [31:0]          reg_rdata,
    output logic [31:0]          reg_wdata,
    output logic [3:0]           reg_wstrb,
    output logic                 reg_wr,
    output logic                 read_complete,
    output logic                 busy,
    output logic                 proto_err,
    input  logic                 err_clr
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;
    logic [1:0]  width_q;
    logic        start_wr;
    logic        start_rd;
    logic        wr_capture;
    logic        done_rd;
    logic        done_wr;
    logic        err_set;
    logic [31:0] rd_src;

`ifdef SERIAL_MMIO_SNAPSHOT_EN
    logic [31:0] snapshot;
    assign rd_src = snapshot;
`else
    assign rd_src = reg_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A width code that differs from the latched one (including a return to idle)
    // aborts the transfer, even on the final nibble.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_wr   = 1'b0;
        start_rd   = 1'b0;
        wr_capture = 1'b0;
        done_rd    = 1'b0;
        done_wr    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bus_write_n != W_IDLE) begin
                    start_wr   = 1'b1;
                    err_set    = (bus.bus_read_n != W_IDLE);
                    cnt_next   = 3'd1;
                    state_next = WR;
                end else if (bus.bus_read_n != W_IDLE) begin
                    start_rd   = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = RD;
                end
            end
            RD: begin
                if (bus.bus_read_n != width_q) begin
                    err_set    = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = IDLE;
                end else if ({1'b0, cnt} == nibble_len(width_q) - 4'd1) begin
                    done_rd    = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            WR: begin
                if (bus.bus_write_n != width_q) begin
                    err_set    = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = IDLE;
                end else begin
                    wr_capture = 1'b1;
                    if ({1'b0, cnt} == nibble_len(width_q) - 4'd1) begin
                        done_wr    = 1'b1;
                        cnt_next   = 3'd0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            default: begin
                cnt_next   = 3'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q       <= W_BYTE;
            reg_addr      <= '0;
            reg_wdata     <= 32'h0;
            reg_wstrb     <= 4'h0;
            reg_wr        <= 1'b0;
            read_complete <= 1'b0;
            proto_err     <= 1'b0;
`ifdef SERIAL_MMIO_SNAPSHOT_EN
            snapshot      <= 32'h0;
`endif
        end else begin
            reg_wr        <= done_wr;
            read_complete <= done_rd;
            if (err_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
            // Clearing the word on write start keeps byte/half writes zero-extended.
            if (start_wr) begin
                reg_addr  <= bus.bus_addr;
                width_q   <= bus.bus_write_n;
                reg_wstrb <= wstrb_of(bus.bus_write_n);
                reg_wdata <= {28'h0, bus.bus_nibble_in};
            end
            if (start_rd) begin
                reg_addr <= bus.bus_addr;
                width_q  <= bus.bus_read_n;
`ifdef SERIAL_MMIO_SNAPSHOT_EN
                snapshot <= reg_rdata;
`endif
            end
            if (wr_capture) begin
                reg_wdata[{cnt, 2'b00} +: 4] <= bus.bus_nibble_in;
            end
        end
    end

    always_comb begin
        bus.bus_nibble_out = RESET_NIBBLE;
        if (state == RD) begin
            bus.bus_nibble_out = rd_src[{cnt, 2'b00} +: 4];
        end
    end

    assign busy = (state != IDLE);

endmodule
